pause_ctrl: RTL and testbench
=============================

PAUSE_CTRL -- requirements
Module: pause_ctrl

Interface
REQ-001 SHALL have parameter DIM_CYCLES, default 32'h0ABA9500, meaning user-pause cycles before dimming (~10 s at 18 MHz).
REQ-002 SHALL have parameter VBL_TIMEOUT, default 20'd600000, meaning the maximum number of cycles spent waiting for vblank before pause is forced.
REQ-003 SHALL have port clk_sys  in  1  system clock; all logic in this single domain.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port btn_pause  in  1  user pause button, level, already synchronous to clk_sys.
REQ-006 SHALL have port osd_status  in  1  OSD open.
REQ-007 SHALL have port osd_pause_en  in  1  enables pause-while-OSD-open.
REQ-008 SHALL have port hs_req  in  1  hiscore module requests RAM access (level).
REQ-009 SHALL have port vblank  in  1  core vertical blank, synchronous to clk_sys.
REQ-010 SHALL have port rgb_in  in  8  core pixel {R[2:0],G[2:0],B[1:0]}.
REQ-011 SHALL have port pause  out  1  freeze to core.
REQ-012 SHALL have port hs_grant  out  1  hiscore access granted.
REQ-013 SHALL have port user_paused  out  1  user toggle state.
REQ-014 SHALL have port dim  out  1  dimming active.
REQ-015 SHALL have port rgb_out  out  8  pixel to video stage, same packing as rgb_in.

Function
REQ-016 SHALL detect the btn_pause rising edge with a 1-cycle delay register; each edge SHALL invert user_paused, and holding the button SHALL produce no further toggles.
REQ-017 SHALL form req = user_paused | hs_req | (osd_status & osd_pause_en).
REQ-018 SHALL implement FSM states RUN, WAIT_VBL, PAUSED; pause=1 only in PAUSED.
REQ-019 SHALL transition RUN->WAIT_VBL when req=1; the WAIT_VBL timeout counter SHALL clear on entry.
REQ-020 SHALL transition WAIT_VBL->PAUSED on a vblank rising edge (vblank=1, previous vblank=0), or when the timeout counter reaches VBL_TIMEOUT-1.
REQ-021 SHALL transition WAIT_VBL->RUN when req=0; this SHALL take priority over a simultaneous vblank edge or timeout.
REQ-022 SHALL transition PAUSED->RUN on the cycle after req=0 is sampled, with no vblank alignment on resume.
REQ-023 SHALL assert pause one cycle after the qualifying vblank edge.
REQ-024 SHALL drive hs_grant = hs_req & (state==PAUSED), registered, so that hs_grant rises 1 cycle after pause rises and falls 1 cycle after hs_req falls.
REQ-025 SHALL run a 32-bit dim counter only while user_paused=1 and state==PAUSED; the counter SHALL saturate at DIM_CYCLES.
REQ-026 SHALL clear the dim counter immediately when user_paused=0, whether or not OSD or hiscore still hold pause.
REQ-027 SHALL assert dim when dim counter == DIM_CYCLES.
REQ-028 SHALL register rgb_out with 1-cycle latency: rgb_out = dim ? {R>>1, G>>1, B>>1} (per field, zero-filled MSB) : rgb_in.
REQ-029 SHALL keep rgb_out unaffected by pause except via dim.
REQ-030 SHALL have the timeout counter be at least 20 bits and never wrap.

Reset
REQ-031 SHALL, while reset_n=0, asynchronously force state=RUN, pause=0, hs_grant=0, user_paused=0, dim=0, rgb_out=8'h00, and clear all counters and edge registers.
REQ-032 SHALL, on reset asserted mid-pause, deassert pause and hs_grant immediately; after release, with req still 1, the FSM SHALL re-enter WAIT_VBL.
REQ-033 SHALL, on release of reset with btn_pause held high, not toggle user_paused, because the edge register resets to 0 and is then loaded with 1 on the first clock before any edge is detected.

Verification
REQ-034 SHALL cover: btn_pause pulse, vblank edge 100 cycles later -> pause=1 at cycle 101, user_paused=1; a second pulse -> pause=0 one cycle after.
REQ-035 SHALL cover: hs_req=1, vblank never toggles, VBL_TIMEOUT=1000 -> pause=1 after 1000 cycles, hs_grant=1 one cycle later; hs_req=0 -> hs_grant=0 next cycle, pause=0 the cycle after.
REQ-036 SHALL cover: osd_status=1, osd_pause_en=0 -> pause stays 0; osd_pause_en=1 -> pause=1 at the next vblank edge.
REQ-037 SHALL cover: user pause, DIM_CYCLES=16, rgb_in=8'hFF -> dim=1 after 16 paused cycles, rgb_out=8'h6D (011_011_01); unpause -> dim=0, rgb_out=8'hFF.
REQ-038 SHALL cover: req dropped in WAIT_VBL on the same cycle as the vblank edge -> state RUN, pause never asserted.
REQ-039 SHALL cover: reset_n pulsed low while PAUSED with hs_req=1 -> all outputs 0 asynchronously; hs_grant re-asserts only after a new vblank edge or timeout.

Source files
------------

// File: rtl/pause_ctrl.sv
// pause_ctrl: pauses the core on user request, OSD-open or hiscore access.
// Pause is aligned to the start of vertical blank (with a timeout fallback so
// a core without vblank cannot stall a request forever); resume happens as
// soon as no request is pending. A long user pause dims the picture.
//
// Ports:
//   clk_sys      in   system clock, single domain
//   reset_n      in   asynchronous active-low reset
//   btn_pause    in   user pause button (level, synchronous)
//   osd_status   in   OSD open
//   osd_pause_en in   allow pausing while OSD is open
//   hs_req       in   hiscore module RAM access request (level)
//   vblank       in   core vertical blank
//   rgb_in  [7:0] in  core pixel {R[2:0],G[2:0],B[1:0]}
//   pause        out  freeze to core
//   hs_grant     out  hiscore access granted (core frozen)
//   user_paused  out  user toggle state
//   dim          out  dimming active
//   rgb_out [7:0] out pixel to video stage, 1-cycle latency
module pause_ctrl #(
   parameter logic [31:0] DIM_CYCLES  = 32'h0ABA9500,
   parameter int unsigned VBL_TIMEOUT = 20'd600000
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       btn_pause,
   input  logic       osd_status,
   input  logic       osd_pause_en,
   input  logic       hs_req,
   input  logic       vblank,
   input  logic [7:0] rgb_in,
   output logic       pause,
   output logic       hs_grant,
   output logic       user_paused,
   output logic       dim,
   output logic [7:0] rgb_out
);

   // Timeout counter is at least 20 bits, wider if VBL_TIMEOUT needs it.
   localparam int TW = ($clog2(VBL_TIMEOUT + 1) > 20) ? $clog2(VBL_TIMEOUT + 1) : 20;
   localparam logic [TW-1:0] TMO_LAST = TW'(VBL_TIMEOUT - 1);

   typedef enum logic [1:0] {RUN, WAIT_VBL, PAUSED} state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [31:0]     dim_cnt_q, dim_cnt_d;
   logic            btn_q, arm_q, vbl_q;
   logic            user_paused_q, req_q, hs_grant_q;
   logic [7:0]      rgb_q;

   logic            btn_rise, vbl_rise, req;
   logic [7:0]      rgb_dim;

   // arm_q blocks edge detection on the first clock after reset, so a button
   // held through reset release is not seen as a press.
   assign btn_rise = arm_q & btn_pause & ~btn_q;
   assign vbl_rise = vblank & ~vbl_q;
   assign req      = user_paused_q | hs_req | (osd_status & osd_pause_en);

   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      case (state_q)
         RUN: begin
            tmo_d = '0;
            if (req) state_d = WAIT_VBL;
         end
         WAIT_VBL: begin
            // Dropped request wins over a simultaneous vblank edge/timeout.
            if (!req)
               state_d = RUN;
            else if (vbl_rise || (tmo_q == TMO_LAST))
               state_d = PAUSED;
            else
               tmo_d = tmo_q + TW'(1);
         end
         PAUSED: begin
            // Resume uses the registered request: leave one cycle after
            // req=0 has been sampled, no vblank alignment.
            if (!req_q) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      dim_cnt_d = dim_cnt_q;
      if (!user_paused_q)
         dim_cnt_d = '0;
      else if ((state_q == PAUSED) && (dim_cnt_q != DIM_CYCLES))
         dim_cnt_d = dim_cnt_q + 32'd1;
   end

   // Halve each colour field, zero-filling its MSB.
   assign rgb_dim = {1'b0, rgb_in[7:6], 1'b0, rgb_in[4:3], 1'b0, rgb_in[1]};

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= RUN;
         tmo_q         <= '0;
         dim_cnt_q     <= '0;
         btn_q         <= 1'b0;
         arm_q         <= 1'b0;
         vbl_q         <= 1'b0;
         user_paused_q <= 1'b0;
         req_q         <= 1'b0;
         hs_grant_q    <= 1'b0;
         rgb_q         <= 8'h00;
      end else begin
         state_q       <= state_d;
         tmo_q         <= tmo_d;
         dim_cnt_q     <= dim_cnt_d;
         btn_q         <= btn_pause;
         arm_q         <= 1'b1;
         vbl_q         <= vblank;
         user_paused_q <= user_paused_q ^ btn_rise;
         req_q         <= req;
         hs_grant_q    <= hs_req & (state_q == PAUSED);
         rgb_q         <= dim ? rgb_dim : rgb_in;
      end
   end

   assign pause       = (state_q == PAUSED);
   assign hs_grant    = hs_grant_q;
   assign user_paused = user_paused_q;
   assign dim         = user_paused_q & (state_q == PAUSED) & (dim_cnt_q == DIM_CYCLES);
   assign rgb_out     = rgb_q;

endmodule

// File: tb/tb_pause_ctrl.sv
module tb_pause_ctrl;

   logic       clk_sys = 1'b0;
   logic       reset_n;
   logic       btn_pause, osd_status, osd_pause_en, hs_req, vblank;
   logic [7:0] rgb_in;
   logic       pause, hs_grant, user_paused, dim;
   logic [7:0] rgb_out;

   int tests = 0;
   int fails = 0;

   always #5 clk_sys = ~clk_sys;

   pause_ctrl #(.DIM_CYCLES(32'd16), .VBL_TIMEOUT(1000)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .btn_pause(btn_pause),
      .osd_status(osd_status), .osd_pause_en(osd_pause_en), .hs_req(hs_req),
      .vblank(vblank), .rgb_in(rgb_in), .pause(pause), .hs_grant(hs_grant),
      .user_paused(user_paused), .dim(dim), .rgb_out(rgb_out)
   );

   // Inputs change and outputs are sampled at the falling edge.
   task tick(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task test_reset;
      rgb_in = 8'hA5;
      tick(3);
      tests++; if (pause !== 1'b0) begin fails++; $display("FAIL reset_pause: got %b want 0", pause); end
      tests++; if (hs_grant !== 1'b0) begin fails++; $display("FAIL reset_grant: got %b want 0", hs_grant); end
      tests++; if (user_paused !== 1'b0) begin fails++; $display("FAIL reset_user: got %b want 0", user_paused); end
      tests++; if (dim !== 1'b0) begin fails++; $display("FAIL reset_dim: got %b want 0", dim); end
      tests++; if (rgb_out !== 8'h00) begin fails++; $display("FAIL reset_rgb: got %h want 00", rgb_out); end
      reset_n = 1'b1;
      tick(2);
      tests++; if (rgb_out !== 8'hA5) begin fails++; $display("FAIL rgb_pass: got %h want a5", rgb_out); end
      tests++; if (pause !== 1'b0) begin fails++; $display("FAIL idle_pause: got %b want 0", pause); end
   endtask

   task test_user_pause;
      btn_pause = 1'b1; tick(1); btn_pause = 1'b0;
      tests++; if (user_paused !== 1'b1) begin fails++; $display("FAIL up_toggle_on: got %b want 1", user_paused); end
      tick(99);
      tests++; if (pause !== 1'b0) begin fails++; $display("FAIL up_wait_vbl: got %b want 0", pause); end
      vblank = 1'b1; tick(1); vblank = 1'b0;
      tests++; if (pause !== 1'b1) begin fails++; $display("FAIL up_pause_on: got %b want 1", pause); end
      btn_pause = 1'b1; tick(1);
      tests++; if (user_paused !== 1'b0) begin fails++; $display("FAIL up_toggle_off: got %b want 0", user_paused); end
      btn_pause = 1'b0; tick(1);
      tests++; if (pause !== 1'b1) begin fails++; $display("FAIL up_req_sample: got %b want 1", pause); end
      tick(1);
      tests++; if (pause !== 1'b0) begin fails++; $display("FAIL up_pause_off: got %b want 0", pause); end
   endtask

   task test_timeout_hiscore;
      hs_req = 1'b1;
      tick(1000);
      tests++; if (pause !== 1'b0) begin fails++; $display("FAIL tmo_early: got %b want 0", pause); end
      tick(1);
      tests++; if (pause !== 1'b1) begin fails++; $display("FAIL tmo_pause: got %b want 1", pause); end
      tests++; if (hs_grant !== 1'b0) begin fails++; $display("FAIL tmo_grant_early: got %b want 0", hs_grant); end
      tick(1);
      tests++; if (hs_grant !== 1'b1) begin fails++; $display("FAIL tmo_grant: got %b want 1", hs_grant); end
      tests++; if (user_paused !== 1'b0) begin fails++; $display("FAIL tmo_user: got %b want 0", user_paused); end
      hs_req = 1'b0; tick(1);
      tests++; if (hs_grant !== 1'b0) begin fails++; $display("FAIL tmo_grant_off: got %b want 0", hs_grant); end
      tests++; if (pause !== 1'b1) begin fails++; $display("FAIL tmo_pause_hold: got %b want 1", pause); end
      tick(1);
      tests++; if (pause !== 1'b0) begin fails++; $display("FAIL tmo_pause_off: got %b want 0", pause); end
   endtask

   task test_osd;
      osd_status = 1'b1; osd_pause_en = 1'b0;
      tick(5); vblank = 1'b1; tick(1); vblank = 1'b0; tick(3);
      tests++; if (pause !== 1'b0) begin fails++; $display("FAIL osd_disabled: got %b want 0", pause); end
      osd_pause_en = 1'b1; tick(4);
      tests++; if (pause !== 1'b0) begin fails++; $display("FAIL osd_wait: got %b want 0", pause); end
      vblank = 1'b1; tick(1); vblank = 1'b0;
      tests++; if (pause !== 1'b1) begin fails++; $display("FAIL osd_pause: got %b want 1", pause); end
      tests++; if (hs_grant !== 1'b0) begin fails++; $display("FAIL osd_grant: got %b want 0", hs_grant); end
      osd_pause_en = 1'b0; tick(2);
      tests++; if (pause !== 1'b0) begin fails++; $display("FAIL osd_resume: got %b want 0", pause); end
      osd_status = 1'b0;
   endtask

   task test_dim;
      rgb_in = 8'hFF;
      btn_pause = 1'b1; tick(1); btn_pause = 1'b0; tick(1);
      vblank = 1'b1; tick(1); vblank = 1'b0;
      tests++; if (pause !== 1'b1) begin fails++; $display("FAIL dim_pause: got %b want 1", pause); end
      tick(15);
      tests++; if (dim !== 1'b0) begin fails++; $display("FAIL dim_early: got %b want 0", dim); end
      tick(1);
      tests++; if (dim !== 1'b1) begin fails++; $display("FAIL dim_on: got %b want 1", dim); end
      tests++; if (rgb_out !== 8'hFF) begin fails++; $display("FAIL dim_rgb_lat: got %h want ff", rgb_out); end
      tick(1);
      tests++; if (rgb_out !== 8'h6D) begin fails++; $display("FAIL dim_rgb: got %h want 6d", rgb_out); end
      hs_req = 1'b1; tick(5);
      tests++; if (dim !== 1'b1) begin fails++; $display("FAIL dim_sat: got %b want 1", dim); end
      tests++; if (hs_grant !== 1'b1) begin fails++; $display("FAIL dim_grant: got %b want 1", hs_grant); end
      btn_pause = 1'b1; tick(1); btn_pause = 1'b0;
      tests++; if (dim !== 1'b0) begin fails++; $display("FAIL dim_off: got %b want 0", dim); end
      tick(1);
      tests++; if (rgb_out !== 8'hFF) begin fails++; $display("FAIL dim_rgb_off: got %h want ff", rgb_out); end
      tick(3);
      tests++; if (pause !== 1'b1) begin fails++; $display("FAIL dim_hs_hold: got %b want 1", pause); end
      tests++; if (dim !== 1'b0) begin fails++; $display("FAIL dim_hs_nodim: got %b want 0", dim); end
      hs_req = 1'b0; tick(2);
      tests++; if (pause !== 1'b0) begin fails++; $display("FAIL dim_resume: got %b want 0", pause); end
   endtask

   task test_req_drop;
      logic seen;
      seen = 1'b0;
      hs_req = 1'b1; tick(4);
      hs_req = 1'b0; vblank = 1'b1; tick(1); vblank = 1'b0;
      seen = pause;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         seen = seen | pause;
      end
      tests++; if (seen !== 1'b0) begin fails++; $display("FAIL drop_no_pause: got %b want 0", seen); end
      tests++; if (hs_grant !== 1'b0) begin fails++; $display("FAIL drop_grant: got %b want 0", hs_grant); end
   endtask

   task test_reset_mid_pause;
      rgb_in = 8'hFF;
      btn_pause = 1'b1; tick(1); btn_pause = 1'b0;
      hs_req = 1'b1; tick(1);
      vblank = 1'b1; tick(1); vblank = 1'b0;
      tick(20);
      tests++; if ({pause, hs_grant, dim} !== 3'b111) begin fails++; $display("FAIL rst_pre: got %b want 111", {pause, hs_grant, dim}); end
      tests++; if (rgb_out !== 8'h6D) begin fails++; $display("FAIL rst_pre_rgb: got %h want 6d", rgb_out); end
      #2 reset_n = 1'b0;
      #1;
      tests++; if ({pause, hs_grant, user_paused, dim} !== 4'b0000) begin fails++; $display("FAIL rst_async: got %b want 0000", {pause, hs_grant, user_paused, dim}); end
      tests++; if (rgb_out !== 8'h00) begin fails++; $display("FAIL rst_async_rgb: got %h want 00", rgb_out); end
      tick(2);
      reset_n = 1'b1;
      tick(50);
      tests++; if ({pause, hs_grant} !== 2'b00) begin fails++; $display("FAIL rst_rewait: got %b want 00", {pause, hs_grant}); end
      vblank = 1'b1; tick(1); vblank = 1'b0;
      tests++; if ({pause, hs_grant} !== 2'b10) begin fails++; $display("FAIL rst_repause: got %b want 10", {pause, hs_grant}); end
      tick(1);
      tests++; if (hs_grant !== 1'b1) begin fails++; $display("FAIL rst_regrant: got %b want 1", hs_grant); end
      hs_req = 1'b0; tick(3);
      tests++; if (pause !== 1'b0) begin fails++; $display("FAIL rst_resume: got %b want 0", pause); end
   endtask

   task test_btn_held_reset;
      reset_n = 1'b0; btn_pause = 1'b1;
      tick(2);
      reset_n = 1'b1;
      tick(4);
      tests++; if (user_paused !== 1'b0) begin fails++; $display("FAIL held_no_toggle: got %b want 0", user_paused); end
      tests++; if (pause !== 1'b0) begin fails++; $display("FAIL held_no_pause: got %b want 0", pause); end
      btn_pause = 1'b0; tick(2);
      btn_pause = 1'b1; tick(1); btn_pause = 1'b0;
      tests++; if (user_paused !== 1'b1) begin fails++; $display("FAIL held_next_press: got %b want 1", user_paused); end
      tick(2);
      btn_pause = 1'b1; tick(1); btn_pause = 1'b0;
      tests++; if (user_paused !== 1'b0) begin fails++; $display("FAIL held_release: got %b want 0", user_paused); end
      tick(3);
      tests++; if (pause !== 1'b0) begin fails++; $display("FAIL held_end_pause: got %b want 0", pause); end
   endtask

   initial begin
      reset_n = 1'b0; btn_pause = 1'b0; osd_status = 1'b0; osd_pause_en = 1'b0;
      hs_req = 1'b0; vblank = 1'b0; rgb_in = 8'h00;
      test_reset;
      test_user_pause;
      test_timeout_hiscore;
      test_osd;
      test_dim;
      test_req_drop;
      test_reset_mid_pause;
      test_btn_held_reset;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
